// File: rtl/al_unit_pkg.sv
// Shared opcodes, FSM state encoding and opcode-class helpers for the
// sequential ALU and its iterative multiply/divide core.
package al_unit_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_NOR   = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b0110;
    localparam logic [3:0] ALU_SLTU  = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_SRA   = 4'b1010;
    localparam logic [3:0] ALU_LUI   = 4'b1011;
    localparam logic [3:0] ALU_MULU  = 4'b1100;
    localparam logic [3:0] ALU_MULHU = 4'b1101;
    localparam logic [3:0] ALU_DIVU  = 4'b1110;
    localparam logic [3:0] ALU_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return op[3] & op[2];
    endfunction

    function automatic logic is_divide(input logic [3:0] op);
        return op[3:1] == 3'b111;
    endfunction

endpackage

// File: rtl/al_iter_core.sv
// Iterative unsigned multiplier / restoring divider sharing one 2*WIDTH
// accumulator. res_hi/res_lo show the accumulator as it will be after this step.
module al_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               mode_q, mode_d;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;

    // Multiply: add B into the high half on a set LSB, then shift right.
    // Divide: shift the next dividend bit into the remainder and try to subtract.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        if (!mode_q) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!rem_diff[WIDTH]) begin
            acc_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        mode_d = mode_q;
        if (load) begin
            acc_d  = {{WIDTH{1'b0}}, op_a};
            b_d    = op_b;
            mode_d = mode;
        end else if (step) begin
            acc_d = acc_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q  <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            mode_q <= mode_d;
        end
    end

    assign res_hi = acc_step[2*WIDTH-1:WIDTH];
    assign res_lo = acc_step[WIDTH-1:0];

endmodule

// File: rtl/al_unit_seq.sv
// Multi-cycle ALU: single-cycle ops register in one clock, mul/div iterate
// WIDTH steps in al_iter_core. dbg_state exposes the FSM state.
module al_unit_seq
    import al_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cu_start,
    input  logic [3:0]       cu_aluc,
    input  logic [WIDTH-1:0] alu_ra,
    input  logic [WIDTH-1:0] alu_rb,
    output logic             alu_busy,
    output logic             alu_done,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_zero,
    output logic             alu_overflow,
    output state_e           dbg_state
);

    localparam int SHAMT_W = $clog2(WIDTH);

    // Handshake: cu_start is taken on any cycle alu_busy is low (IDLE or DONE);
    // alu_done is high for exactly the one cycle after the result registers.
    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               sel_hi_q, sel_hi_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d, ovf_q, ovf_d;
    logic               accept, div_zero, core_load, core_step;
    logic [WIDTH-1:0]   sc_result, core_hi, core_lo;
    logic               sc_ovf;
    logic [SHAMT_W-1:0] shamt;

    assign accept    = cu_start && (state_q != ST_RUN);
    assign div_zero  = is_divide(cu_aluc) && (alu_rb == '0);
    assign core_load = accept && is_iterative(cu_aluc) && !div_zero;
    assign core_step = (state_q == ST_RUN);
    assign shamt     = alu_rb[SHAMT_W-1:0];

    al_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .resetn (resetn),
        .load   (core_load),
        .step   (core_step),
        .mode   (cu_aluc[1]),
        .op_a   (alu_ra),
        .op_b   (alu_rb),
        .res_hi (core_hi),
        .res_lo (core_lo)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_hi_q <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_hi_q <= sel_hi_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) state_d = core_load ? ST_RUN : ST_DONE;
                else        state_d = ST_IDLE;
            end
            ST_RUN:  if (cnt_q == '0) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (cu_aluc)
            ALU_ADD: begin
                sc_result = alu_ra + alu_rb;
                sc_ovf    = (alu_ra[WIDTH-1] == alu_rb[WIDTH-1]) && (sc_result[WIDTH-1] != alu_ra[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_result = alu_ra - alu_rb;
                sc_ovf    = (alu_ra[WIDTH-1] != alu_rb[WIDTH-1]) && (sc_result[WIDTH-1] != alu_ra[WIDTH-1]);
            end
            ALU_AND:  sc_result = alu_ra & alu_rb;
            ALU_OR:   sc_result = alu_ra | alu_rb;
            ALU_XOR:  sc_result = alu_ra ^ alu_rb;
            ALU_NOR:  sc_result = ~(alu_ra | alu_rb);
            ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(alu_ra) < $signed(alu_rb)};
            ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, alu_ra < alu_rb};
            ALU_SLL:  sc_result = alu_ra << shamt;
            ALU_SRL:  sc_result = alu_ra >> shamt;
            ALU_SRA:  sc_result = $signed(alu_ra) >>> shamt;
            ALU_LUI:  sc_result = alu_rb << (WIDTH / 2);
            default:  sc_result = '0;
        endcase
    end

    // Result/flag registers move only on the edge that enters DONE.
    always_comb begin
        cnt_d    = cnt_q;
        sel_hi_d = sel_hi_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        if (core_load) begin
            cnt_d    = SHAMT_W'(WIDTH - 1);
            sel_hi_d = cu_aluc[0];
        end else if (accept) begin
            if (div_zero) begin
                result_d = (cu_aluc == ALU_DIVU) ? {WIDTH{1'b1}} : alu_ra;
                ovf_d    = 1'b0;
            end else begin
                result_d = sc_result;
                ovf_d    = sc_ovf;
            end
        end else if (core_step) begin
            if (cnt_q == '0) begin
                result_d = sel_hi_q ? core_hi : core_lo;
                ovf_d    = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        zero_d = (result_d == '0);
    end

    always_comb begin
        alu_busy  = (state_q == ST_RUN);
        alu_done  = (state_q == ST_DONE);
        dbg_state = state_q;
    end

    assign alu_result   = result_q;
    assign alu_zero     = zero_q;
    assign alu_overflow = ovf_q;

endmodule
